// File: rtl/nanov_spi_fetch.sv
// nanoV instruction fetch: streams 32-bit words from an SPI flash in READ (0x03)
// continuous mode into a 2-entry queue presented over a valid/ready handshake.
module nanov_spi_fetch #(
    parameter logic [23:0] RESET_ADDR = 24'h000000,
    parameter int unsigned DUMMY_BITS = 0
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        o_spi_select,
    output logic        o_spi_clk_en,
    output logic        o_spi_out,
    input  logic        i_spi_data_in,
    input  logic        i_branch_valid,
    input  logic [23:0] i_branch_addr,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic [23:0] o_instr_pc
);
    typedef enum logic [2:0] {
        S_DESEL,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA
    } state_t;

    localparam logic [7:0]  CMD_READ      = 8'h03;
    localparam logic [23:0] RESET_ALIGNED = {RESET_ADDR[23:2], 2'b00};
    localparam logic [4:0]  DUMMY_LAST    = 5'(DUMMY_BITS - 1);

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [23:0] r_addr;
    logic [31:0] r_shift;
    logic        r_spi_select;
    logic        r_spi_clk_en;
    logic        r_spi_out;
    logic [1:0]  r_count;
    logic        r_instr_valid;
    logic [31:0] r_head_data;
    logic [23:0] r_head_pc;
    logic [31:0] r_tail_data;
    logic [23:0] r_tail_pc;

    state_t      w_state_nxt;
    logic [4:0]  w_cnt_nxt;
    logic [23:0] w_addr_nxt;
    logic [31:0] w_shift_nxt;
    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_count_nxt;
    logic        w_clk_en_nxt;
    logic        w_out_nxt;
    logic [31:0] w_word;
    logic        w_push_to_head;
    logic        w_unused_addr_bits;

    assign w_unused_addr_bits = &{1'b0, i_branch_addr[1:0]};

    assign w_pop  = r_instr_valid && i_instr_ready && !i_branch_valid;
    // Flash delivers b0 first in the top byte of the shifter; reorder to {b3,b2,b1,b0}.
    assign w_word = {w_shift_nxt[7:0], w_shift_nxt[15:8], w_shift_nxt[23:16], w_shift_nxt[31:24]};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        case (r_state)
            S_DESEL: begin
                w_state_nxt = S_CMD;
                w_cnt_nxt   = 5'd7;
            end
            S_CMD: begin
                if (r_cnt == 5'd0) begin
                    w_state_nxt = S_ADDR;
                    w_cnt_nxt   = 5'd23;
                end else begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end
            end
            S_ADDR: begin
                if (r_cnt != 5'd0) begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end else if (DUMMY_BITS != 0) begin
                    w_state_nxt = S_DUMMY;
                    w_cnt_nxt   = DUMMY_LAST;
                end else begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = 5'd31;
                end
            end
            S_DUMMY: begin
                if (r_cnt == 5'd0) begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = 5'd31;
                end else begin
                    w_cnt_nxt = r_cnt - 5'd1;
                end
            end
            S_DATA: begin
                if (r_spi_clk_en) begin
                    w_shift_nxt = {r_shift[30:0], i_spi_data_in};
                    if (r_cnt == 5'd0) begin
                        w_push    = 1'b1;
                        w_cnt_nxt = 5'd31;
                    end else begin
                        w_cnt_nxt = r_cnt - 5'd1;
                    end
                end
            end
            default: w_state_nxt = S_DESEL;
        endcase
        if (i_branch_valid) begin
            w_state_nxt = S_DESEL;
            w_push      = 1'b0;
        end
    end

    always_comb begin
        w_addr_nxt = r_addr;
        if (i_branch_valid) begin
            w_addr_nxt = {i_branch_addr[23:2], 2'b00};
        end else if (w_push) begin
            w_addr_nxt = r_addr + 24'd4;
        end
        w_count_nxt = i_branch_valid ? 2'd0 : (r_count + {1'b0, w_push} - {1'b0, w_pop});
        // A word boundary with both slots still occupied holds the flash clock.
        w_clk_en_nxt = (w_state_nxt != S_DESEL) &&
                       !((w_state_nxt == S_DATA) && (w_cnt_nxt == 5'd31) && (w_count_nxt == 2'd2));
        w_out_nxt = 1'b0;
        case (w_state_nxt)
            S_CMD:   w_out_nxt = CMD_READ[w_cnt_nxt[2:0]];
            S_ADDR:  w_out_nxt = r_addr[w_cnt_nxt];
            default: w_out_nxt = 1'b0;
        endcase
        w_push_to_head = (r_count == 2'd0) || ((r_count == 2'd1) && w_pop);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= S_DESEL;
            r_cnt        <= 5'd0;
            r_addr       <= RESET_ALIGNED;
            r_shift      <= 32'd0;
            r_spi_select <= 1'b1;
            r_spi_clk_en <= 1'b0;
            r_spi_out    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_addr       <= w_addr_nxt;
            r_shift      <= w_shift_nxt;
            r_spi_select <= (w_state_nxt == S_DESEL);
            r_spi_clk_en <= w_clk_en_nxt;
            r_spi_out    <= w_out_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count       <= 2'd0;
            r_instr_valid <= 1'b0;
            r_head_data   <= 32'd0;
            r_head_pc     <= 24'd0;
            r_tail_data   <= 32'd0;
            r_tail_pc     <= 24'd0;
        end else begin
            r_count       <= w_count_nxt;
            r_instr_valid <= (w_count_nxt != 2'd0);
            if (w_pop && (r_count == 2'd2)) begin
                r_head_data <= r_tail_data;
                r_head_pc   <= r_tail_pc;
            end
            if (w_push) begin
                if (w_push_to_head) begin
                    r_head_data <= w_word;
                    r_head_pc   <= r_addr;
                end else begin
                    r_tail_data <= w_word;
                    r_tail_pc   <= r_addr;
                end
            end
        end
    end

    assign o_spi_select  = r_spi_select;
    assign o_spi_clk_en  = r_spi_clk_en;
    assign o_spi_out     = r_spi_out;
    assign o_instr_valid = r_instr_valid;
    assign o_instr       = r_head_data;
    assign o_instr_pc    = r_head_pc;

endmodule

// File: tb/tb_nanov_spi_fetch.sv
// Bench for nanov_spi_fetch: a bit-level SPI flash model plus scenario tasks
// comparing the fetched stream against words computed from the flash contents.
module tb_nanov_spi_fetch;
    logic        clk = 1'b0;
    logic        rstn;
    logic        spi_select;
    logic        spi_clk_en;
    logic        spi_out;
    logic        spi_miso;
    logic        branch_valid;
    logic [23:0] branch_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [23:0] instr_pc;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] seed;
    logic [23:0] exp_pc;

    always #5 clk = ~clk;

    nanov_spi_fetch dut (
        .clk           (clk),
        .rstn          (rstn),
        .o_spi_select  (spi_select),
        .o_spi_clk_en  (spi_clk_en),
        .o_spi_out     (spi_out),
        .i_spi_data_in (spi_miso),
        .i_branch_valid(branch_valid),
        .i_branch_addr (branch_addr),
        .o_instr_valid (instr_valid),
        .i_instr_ready (instr_ready),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc)
    );

    // Flash contents: fixed 13 00 00 00 at address 0, seeded hash elsewhere.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        logic [31:0] h;
        if (a == 24'd0) return 8'h13;
        if (a < 24'd4) return 8'h00;
        h = ({8'd0, a} * 32'h9E3779B1) ^ seed;
        return h[20:13];
    endfunction

    function automatic logic [31:0] mem_word(input logic [23:0] pc);
        logic [23:0] a1, a2, a3;
        a1 = pc + 24'd1;
        a2 = pc + 24'd2;
        a3 = pc + 24'd3;
        return {mem_byte(a3), mem_byte(a2), mem_byte(a1), mem_byte(pc)};
    endfunction

    // Flash: counts clocked bits since select; bits 8..31 carry the address, then bytes stream.
    int          fl_n;
    int          fl_d;
    logic [23:0] fl_addr;
    logic [23:0] fl_ba;
    logic [7:0]  fl_b;
    always @(negedge clk) begin
        if (spi_select === 1'b1) begin
            fl_n = 0;
        end else if (spi_clk_en === 1'b1) begin
            if (fl_n >= 8 && fl_n < 32) fl_addr = {fl_addr[22:0], spi_out};
            if (fl_n >= 32) begin
                fl_d     = fl_n - 32;
                fl_ba    = fl_addr + 24'(fl_d / 8);
                fl_b     = mem_byte(fl_ba);
                spi_miso = fl_b[7 - (fl_d % 8)];
            end
            fl_n++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic redirect(input logic [23:0] a);
        branch_valid = 1'b1;
        branch_addr  = a;
        tick();
        branch_valid = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        logic [31:0] seq;
        rstn = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (spi_select !== 1'b1 || spi_clk_en !== 1'b0 || spi_out !== 1'b0 ||
            instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== 24'd0) begin
            n_err++;
            $display("FAIL reset_values: sel=%b clk_en=%b out=%b valid=%b instr=%h pc=%h, required 1 0 0 0 0 0",
                     spi_select, spi_clk_en, spi_out, instr_valid, instr, instr_pc);
        end
        rstn = 1'b1;
        cyc  = 0;
        n_vec++;
        if (spi_select !== 1'b1 || spi_clk_en !== 1'b0) begin
            n_err++;
            $display("FAIL reset_desel: sel=%b clk_en=%b, required 1 0", spi_select, spi_clk_en);
        end
        seq = {8'h03, 24'h000000};
        for (int c = 1; c <= 32; c++) begin
            tick();
            n_vec++;
            if (spi_select !== 1'b0 || spi_clk_en !== 1'b1 || spi_out !== seq[32-c]) begin
                n_err++;
                $display("FAIL reset_mosi c=%0d: sel=%b clk_en=%b out=%b, required 0 1 %b",
                         c, spi_select, spi_clk_en, spi_out, seq[32-c]);
            end
        end
        go_to(64);
        n_vec++;
        if (instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_early_valid: valid=%b at cycle 64, required 0", instr_valid);
        end
        tick();
        n_vec++;
        if (instr_valid !== 1'b1 || instr !== 32'h00000013 || instr_pc !== 24'd0) begin
            n_err++;
            $display("FAIL reset_first_word: valid=%b instr=%h pc=%h, required 1 00000013 000000",
                     instr_valid, instr, instr_pc);
        end
    endtask

    task automatic test_stream();
        instr_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            go_to(64 + 32 * k);
            n_vec++;
            if (instr_valid !== 1'b0) begin
                n_err++;
                $display("FAIL stream_gap k=%0d: valid=%b, required 0", k, instr_valid);
            end
            tick();
            n_vec++;
            if (instr_valid !== 1'b1 || instr_pc !== 24'(4 * k) || instr !== mem_word(24'(4 * k))) begin
                n_err++;
                $display("FAIL stream_word k=%0d: valid=%b pc=%h instr=%h, required 1 %h %h",
                         k, instr_valid, instr_pc, instr, 24'(4 * k), mem_word(24'(4 * k)));
            end
        end
    endtask

    task automatic test_backpressure();
        int popped;
        int budget;
        instr_ready = 1'b0;
        go_to(192);
        n_vec++;
        if (spi_clk_en !== 1'b1) begin
            n_err++;
            $display("FAIL bp_last_bit: clk_en=%b, required 1", spi_clk_en);
        end
        tick();
        n_vec++;
        if (spi_clk_en !== 1'b0 || spi_select !== 1'b0) begin
            n_err++;
            $display("FAIL bp_pause_start: clk_en=%b sel=%b, required 0 0", spi_clk_en, spi_select);
        end
        go_to(250);
        n_vec++;
        if (spi_clk_en !== 1'b0 || spi_select !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 24'd12) begin
            n_err++;
            $display("FAIL bp_paused: clk_en=%b sel=%b valid=%b pc=%h, required 0 0 1 00000c",
                     spi_clk_en, spi_select, instr_valid, instr_pc);
        end
        instr_ready = 1'b1;
        n_vec++;
        if (instr !== mem_word(24'd12)) begin
            n_err++;
            $display("FAIL bp_head: instr=%h, required %h", instr, mem_word(24'd12));
        end
        tick();
        instr_ready = 1'b0;
        n_vec++;
        if (spi_clk_en !== 1'b1 || instr_valid !== 1'b1 || instr_pc !== 24'd16) begin
            n_err++;
            $display("FAIL bp_resume: clk_en=%b valid=%b pc=%h, required 1 1 000010",
                     spi_clk_en, instr_valid, instr_pc);
        end
        exp_pc = 24'd16;
        popped = 0;
        budget = 0;
        while (popped < 8 && budget < 3000) begin
            instr_ready = 1'($urandom_range(0, 1));
            if (instr_valid === 1'b1 && instr_ready) begin
                n_vec++;
                if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
                    n_err++;
                    $display("FAIL bp_drain: pc=%h instr=%h, required %h %h",
                             instr_pc, instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 24'd4;
                popped++;
            end
            tick();
            budget++;
        end
        n_vec++;
        if (popped < 8) begin
            n_err++;
            $display("FAIL bp_timeout: popped %0d words, required 8", popped);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_branch();
        logic [23:0] a;
        logic [31:0] seq;
        a = 24'($urandom);
        instr_ready = 1'b0;
        redirect(a);
        go_to(65);
        n_vec++;
        if (instr_valid !== 1'b1 || instr_pc !== {a[23:2], 2'b00} || instr !== mem_word({a[23:2], 2'b00})) begin
            n_err++;
            $display("FAIL branch_first: valid=%b pc=%h instr=%h, required 1 %h %h",
                     instr_valid, instr_pc, instr, {a[23:2], 2'b00}, mem_word({a[23:2], 2'b00}));
        end
        go_to(82);
        redirect(24'h000103);
        n_vec++;
        if (instr_valid !== 1'b0 || spi_select !== 1'b1 || spi_clk_en !== 1'b0) begin
            n_err++;
            $display("FAIL branch_flush: valid=%b sel=%b clk_en=%b, required 0 1 0",
                     instr_valid, spi_select, spi_clk_en);
        end
        seq = {8'h03, 24'h000100};
        for (int c = 1; c <= 32; c++) begin
            tick();
            n_vec++;
            if (spi_select !== 1'b0 || spi_out !== seq[32-c]) begin
                n_err++;
                $display("FAIL branch_mosi c=%0d: sel=%b out=%b, required 0 %b", c, spi_select, spi_out, seq[32-c]);
            end
        end
        go_to(65);
        n_vec++;
        if (instr_valid !== 1'b1 || instr_pc !== 24'h000100 || instr !== mem_word(24'h000100)) begin
            n_err++;
            $display("FAIL branch_target: valid=%b pc=%h instr=%h, required 1 000100 %h",
                     instr_valid, instr_pc, instr, mem_word(24'h000100));
        end
    endtask

    task automatic test_branch_push_pop();
        logic [23:0] b, c;
        b = 24'($urandom);
        c = 24'($urandom);
        instr_ready = 1'b0;
        redirect(b);
        go_to(96);
        n_vec++;
        if (instr_valid !== 1'b1 || spi_clk_en !== 1'b1) begin
            n_err++;
            $display("FAIL bpp_setup: valid=%b clk_en=%b, required 1 1", instr_valid, spi_clk_en);
        end
        instr_ready = 1'b1;
        redirect(c);
        for (int k = 0; k <= 64; k++) begin
            n_vec++;
            if (instr_valid !== 1'b0) begin
                n_err++;
                $display("FAIL bpp_dropped k=%0d: valid=%b pc=%h, required 0", k, instr_valid, instr_pc);
            end
            tick();
        end
        n_vec++;
        if (instr_valid !== 1'b1 || instr_pc !== {c[23:2], 2'b00} || instr !== mem_word({c[23:2], 2'b00})) begin
            n_err++;
            $display("FAIL bpp_target: valid=%b pc=%h instr=%h, required 1 %h %h",
                     instr_valid, instr_pc, instr, {c[23:2], 2'b00}, mem_word({c[23:2], 2'b00}));
        end
    endtask

    task automatic test_wrap();
        logic [23:0] pcs [3];
        pcs[0] = 24'hFFFFF8;
        pcs[1] = 24'hFFFFFC;
        pcs[2] = 24'h000000;
        instr_ready = 1'b1;
        redirect(24'hFFFFF8);
        for (int k = 0; k < 3; k++) begin
            go_to(65 + 32 * k);
            n_vec++;
            if (instr_valid !== 1'b1 || instr_pc !== pcs[k] || instr !== mem_word(pcs[k])) begin
                n_err++;
                $display("FAIL wrap k=%0d: valid=%b pc=%h instr=%h, required 1 %h %h",
                         k, instr_valid, instr_pc, instr, pcs[k], mem_word(pcs[k]));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] seq;
        instr_ready = 1'b0;
        redirect(24'($urandom));
        go_to(20);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        cyc  = 0;
        n_vec++;
        if (spi_select !== 1'b1 || spi_clk_en !== 1'b0 || spi_out !== 1'b0 ||
            instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== 24'd0) begin
            n_err++;
            $display("FAIL midreset_values: sel=%b clk_en=%b out=%b valid=%b instr=%h pc=%h, required 1 0 0 0 0 0",
                     spi_select, spi_clk_en, spi_out, instr_valid, instr, instr_pc);
        end
        seq = {8'h03, 24'h000000};
        for (int c = 1; c <= 32; c++) begin
            tick();
            n_vec++;
            if (spi_select !== 1'b0 || spi_clk_en !== 1'b1 || spi_out !== seq[32-c]) begin
                n_err++;
                $display("FAIL midreset_mosi c=%0d: sel=%b clk_en=%b out=%b, required 0 1 %b",
                         c, spi_select, spi_clk_en, spi_out, seq[32-c]);
            end
        end
        go_to(65);
        n_vec++;
        if (instr_valid !== 1'b1 || instr !== 32'h00000013 || instr_pc !== 24'd0) begin
            n_err++;
            $display("FAIL midreset_word: valid=%b instr=%h pc=%h, required 1 00000013 000000",
                     instr_valid, instr, instr_pc);
        end
    endtask

    initial begin
        seed         = $urandom;
        rstn         = 1'b0;
        branch_valid = 1'b0;
        branch_addr  = 24'd0;
        instr_ready  = 1'b0;
        spi_miso     = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_branch();
        test_branch_push_pop();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nanov_spi_fetch.md
# nanov_spi_fetch

Instruction fetch stage for the nanoV bit-serial core: drives an SPI flash in single-bit READ (0x03) continuous mode and assembles the serial stream into 32-bit instruction words. Words are queued in a 2-entry FIFO and handed to the core over a valid/ready handshake, each tagged with its PC. A branch redirect flushes the queue and restarts the flash read at the new address.

## Interface
- RESET_ADDR, 24'h000000: address fetched after reset; bits [1:0] ignored.
- DUMMY_BITS, 0: extra bit cycles between the last address bit and the first data bit, for IO delay compensation.
- clk  in  1  system clock.
- rstn  in  1  reset, synchronous, active-low.
- spi_select  out  1  flash chip select, active-low.
- spi_clk_en  out  1  high in cycles where the SPI clock pulses, called a bit cycle; external logic gates the SPI clock with it.
- spi_out  out  1  MOSI bit, valid for the current bit cycle.
- spi_data_in  in  1  MISO bit, sampled at the posedge ending a bit cycle.
- branch_valid  in  1  redirect request, single cycle.
- branch_addr  in  24  redirect target; bits [1:0] ignored.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  core accepts the head this cycle.
- instr  out  32  instruction word at the FIFO head.
- instr_pc  out  24  byte address of `instr`, with [1:0] = 0.

## Operation
- States:
  - DESEL: spi_select = 1, spi_clk_en = 0, lasts exactly 1 cycle; then CMD.
  - CMD: 8 bit cycles; spi_out = 0x03, MSB first; then ADDR.
  - ADDR: 24 bit cycles; spi_out = fetch address, MSB first; then DUMMY if DUMMY_BITS > 0, else DATA.
  - DUMMY: DUMMY_BITS bit cycles, with spi_in ignored; then DATA.
  - DATA: 32 bit cycles per word, spi_out = 0; loops back to DATA.
- spi_select is 0 in every state except DESEL.
- spi_out is 0 in DESEL and DATA.
- Byte assembly: the flash returns bytes in increasing address order, each byte MSB first. The 4 bytes b0..b3 form {b3,b2,b1,b0}, i.e. RISC-V little-endian.
- Push: on the posedge that samples the 32nd data bit, the word and its address are written to the FIFO. The fetch address then advances by 4, modulo 2^24, so 0xFFFFFC wraps to 0x000000.
- Backpressure:
  - A new word may start only at a word boundary, when FIFO count < 2 or a pop occurs in the same cycle.
  - Otherwise the block stays in DATA with spi_clk_en = 0 and spi_select = 0, pausing the flash clock until a slot frees.
  - A word in progress never pauses, and push into a full FIFO cannot occur.
- Pop: when instr_valid && instr_ready, the head advances. Push and pop in the same cycle are both honoured.
- Redirect: when branch_valid = 1 in any state, regardless of state or partial word:
  - the FIFO is cleared and the partial word discarded;
  - the fetch address becomes {branch_addr[23:2],2'b00};
  - the next cycle is DESEL.
- Redirect beats push and pop in the same cycle: the word completing that cycle is dropped, and instr_valid is 0 the next cycle.
- RESET_ADDR and branch_addr have bits [1:0] forced to 0.

## Timing
- Reset values: spi_select = 1, spi_clk_en = 0, spi_out = 0, instr_valid = 0, instr = 0, instr_pc = 0, FIFO empty, fetch address = RESET_ADDR.
  - The first cycle after reset release is DESEL.
  - Reset asserted mid-transfer restores all of the above on the next posedge.
- Fetch sequence after reset release or redirect, counted from cycle 0 = DESEL, with DUMMY_BITS = 0:
  - cycles 1–8: CMD;
  - cycles 9–32: ADDR;
  - cycles 33–64: first word;
  - instr_valid = 1 from cycle 65.
  - With no backpressure, each following word is valid 32 cycles after the previous one.
  - DUMMY_BITS adds exactly that many cycles.
- All outputs are registered; the FIFO head is visible the cycle after its push.
- spi_clk_en = 1 exactly in the CMD, ADDR, DUMMY and unpaused DATA cycles.

## Test plan
- Reset with RESET_ADDR = 0:
  - spi_out over cycles 1–32 = 00000011 followed by 24 zeros;
  - flash model returns bytes 13 00 00 00;
  - at cycle 65: instr = 32'h00000013, instr_pc = 0.
- Stream with instr_ready held 1: 4 consecutive words arrive 32 cycles apart, with instr_pc 0, 4, 8, 12 and correct byte order.
- instr_ready held 0:
  - two words are queued, then spi_clk_en stays 0 with spi_select = 0;
  - raising instr_ready for 1 cycle resumes clocking the next cycle;
  - no bit of the flash stream is lost or duplicated.
- branch_valid with branch_addr = 24'h000103 at bit 17 of a word:
  - instr_valid = 0 the next cycle;
  - one DESEL cycle follows;
  - the address sent is 0x000100;
  - the first new word has instr_pc = 0x100.
- branch_valid in the same cycle as a push and a pop: the completing word is never presented, and the FIFO is empty afterwards.
- Start at 24'hFFFFF8: the PCs are FFFFF8, FFFFFC, 000000.
- rstn low for 1 cycle mid-ADDR: all reset values are restored, then the sequence restarts with DESEL.
